laser_point_tracker: RTL

// - Upstream of the VGA colour mapper. Scans the live camera pixel stream each frame and finds the

---
 rtl/laser_point_tracker.sv | 94 +++++++++
 1 files changed

// File: rtl/laser_point_tracker.sv
// laser_point_tracker: finds the brightest above-threshold pixel per frame and drives a marker box.
// Optional TRACK_SMOOTH_EN averages the new point with the previous one on consecutive valid frames.
module laser_point_tracker #(
  parameter logic [11:0] THRESH = 12'd2700,
  parameter logic [9:0]  BOX_R  = 10'd4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       run,
  input  logic       pix_valid,
  input  logic       frame_end,
  input  logic [9:0] VGA_R_In,
  input  logic [9:0] VGA_G_In,
  input  logic [9:0] VGA_B_In,
  input  logic [9:0] VGA_X,
  input  logic [9:0] VGA_Y,
  output logic [9:0] point_x,
  output logic [9:0] point_y,
  output logic       point_valid,
  output logic       memory_on,
  output logic [3:0] data
);
  typedef enum logic [1:0] {IDLE, SCAN, LATCH} state_t;
  state_t state, next;
  logic [11:0] lum, best_lum;
  logic [9:0] best_x, best_y, nx, ny;
  logic found, take;
  logic signed [10:0] dx, dy;
  logic [10:0] ax, ay;
  assign lum = {2'b0, VGA_R_In} + {2'b0, VGA_G_In} + {2'b0, VGA_B_In};
  assign take = pix_valid && lum >= THRESH && (!found || lum > best_lum);
`ifdef TRACK_SMOOTH_EN
  logic [10:0] sx, sy;
  assign sx = {1'b0, point_x} + {1'b0, best_x};
  assign sy = {1'b0, point_y} + {1'b0, best_y};
  assign nx = point_valid ? sx[10:1] : best_x;
  assign ny = point_valid ? sy[10:1] : best_y;
`else
  assign nx = best_x;
  assign ny = best_y;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = run ? SCAN : IDLE;
      SCAN:    next = !run ? IDLE : (frame_end ? LATCH : SCAN);
      default: next = run ? SCAN : IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      best_lum    <= '0;
      best_x      <= '0;
      best_y      <= '0;
      found       <= 1'b0;
      point_x     <= '0;
      point_y     <= '0;
      point_valid <= 1'b0;
      data        <= '0;
    end else begin
      if (state == IDLE && run) begin
        best_lum <= '0;
        found    <= 1'b0;
      end
      if (state == SCAN && take) begin
        best_lum <= lum;
        best_x   <= VGA_X;
        best_y   <= VGA_Y;
        found    <= 1'b1;
      end
      if (state == LATCH) begin
        if (found) begin
          point_x     <= nx;
          point_y     <= ny;
          point_valid <= 1'b1;
          data        <= (data == 4'd15) ? data : data + 4'd1;
        end else begin
          point_valid <= 1'b0;
          data        <= '0;
        end
        best_lum <= '0;
        found    <= 1'b0;
      end
    end
  // Signed 11-bit differences keep the box from wrapping around the screen edges.
  assign dx = $signed({1'b0, VGA_X}) - $signed({1'b0, point_x});
  assign dy = $signed({1'b0, VGA_Y}) - $signed({1'b0, point_y});
  assign ax = dx[10] ? 11'(-dx) : 11'(dx);
  assign ay = dy[10] ? 11'(-dy) : 11'(dy);
  assign memory_on = point_valid && ax <= {1'b0, BOX_R} && ay <= {1'b0, BOX_R};
endmodule
